uart_tx_word_feeder: RTL and testbench
======================================

# uart_tx_word_feeder

Buffered word source that sits directly upstream of the UART data transmitter. Accepts DATA_WIDTH-bit words from a producer over a valid/ready handshake, queues them in an internal FIFO, and drives the transmitter's `data`/`send_en` inputs one word at a time. It waits for the transmitter's `tx_done` before issuing the next word and enforces a programmable inter-word gap and a completion timeout.

## Interface
- DATA_WIDTH, 32: word width; must match the transmitter's DATA_WIDTH.
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW (8).
- GAP_CYCLES, 16: idle clock cycles inserted after each `tx_done` before the next `send_en`; 0 = no gap.
- TIMEOUT_CYCLES, 2000000: maximum cycles spent in WAIT; 24-bit counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- nrst  in  1  reset, synchronous, active-low.
- wr_data  in  DATA_WIDTH  producer word.
- wr_valid  in  1  producer word valid.
- wr_ready  out  1  FIFO can accept; = !full.
- tx_data  out  DATA_WIDTH  to transmitter `data`; registered.
- send_en  out  1  to transmitter `send_en`; one-cycle pulse.
- tx_done  in  1  from transmitter; completion of current word.
- fifo_level  out  FIFO_AW+1  words currently queued (0..2**FIFO_AW).
- busy  out  1  high when state != IDLE or fifo_level != 0.
- timeout_flag  out  1  sticky; set on WAIT timeout.
- timeout_clr  in  1  clears timeout_flag.

## Operation
- FIFO: circular buffer, read/write pointers FIFO_AW+1 bits (wrap bit distinguishes full/empty). Push when wr_valid && wr_ready. Pop only by the FSM in IDLE. Push into a full FIFO is impossible (wr_ready low); simultaneous push and pop in a non-full FIFO leaves fifo_level unchanged.
- FSM states: IDLE, SEND, WAIT, GAP.
  - IDLE: if fifo_level != 0 -> pop head into tx_data, go SEND. Otherwise stay.
  - SEND: send_en = 1 for this single cycle; -> WAIT; timeout counter cleared.
  - WAIT: completion = rising edge of tx_done (tx_done && !tx_done_q, tx_done_q registered, reset 0). On completion -> GAP (or IDLE if GAP_CYCLES = 0). If counter reaches TIMEOUT_CYCLES-1 without completion -> set timeout_flag, go IDLE (word dropped, not retried).
  - GAP: count GAP_CYCLES cycles, then -> IDLE.
- tx_done edges outside WAIT are ignored.
- tx_data holds the last popped word until the next pop; it never changes in SEND/WAIT/GAP.
- timeout_flag: set has priority over timeout_clr in the same cycle.

## Timing
- Reset (nrst low at a clock edge): state IDLE, FIFO emptied (pointers 0), fifo_level 0, wr_ready 1, tx_data 0, send_en 0, busy 0, timeout_flag 0, counters 0, tx_done_q 0. Reset mid-transfer discards queued words; the transmitter is reset from the same nrst.
- Latency: word accepted at edge k into an empty FIFO with FSM in IDLE -> fifo_level = 1 after edge k; pop and tx_data load at edge k+1; send_en high during cycle between edges k+1 and k+2; fifo_level = 0 after edge k+1.
- After completion edge detected at edge m: send_en for the next queued word is high in the cycle after edge m+GAP_CYCLES+1 (GAP count, then IDLE pop, then SEND).
- send_en never high on two consecutive cycles; never high while in WAIT or GAP.
- wr_ready falls in the cycle after the push that fills the FIFO; rises the cycle after the first pop from full.

## Test plan
- Reset: hold nrst low 10 cycles with wr_valid high -> all outputs at reset values, fifo_level stays 0.
- Single word: push 32'h12345678 into empty FIFO, loop transmitter to a UART_DATA_RX at baud_set 4 -> send_en pulse two cycles after acceptance, receiver outputs 32'h12345678, busy falls after GAP.
- Burst: push 32'h87654321, 32'h24680135, 32'hDEADBEEF back-to-back -> three send_en pulses, each after prior tx_done plus GAP_CYCLES+2 cycles, received in order.
- Full FIFO: push 9 words with tx_done held low -> wr_ready low after 8th push (fifo_level 8 then 7 after first pop), 9th accepted only after a pop, no word lost or duplicated.
- Timeout: TIMEOUT_CYCLES=100, never assert tx_done -> timeout_flag set 100 cycles after SEND, FSM returns to IDLE and sends next word; timeout_clr clears it.
- Mid-transfer reset: assert nrst low during WAIT with 3 words queued -> next edge all reset values, no further send_en after release until a new push.

Source files
------------

// File: rtl/uart_tx_word_feeder.sv
// uart_tx_word_feeder
//
// Buffered word source for a UART data transmitter. Words from a producer are
// queued in a small circular FIFO and handed to the transmitter one at a time:
// the FSM pops a word into tx_data, pulses send_en, waits for the rising edge
// of tx_done, then holds off for GAP_CYCLES before the next word. A word whose
// completion never arrives within TIMEOUT_CYCLES is dropped and a sticky
// timeout_flag is raised.
//
// Ports:
//   clk          in   system clock, rising edge
//   nrst         in   synchronous active-low reset
//   wr_data      in   producer word
//   wr_valid     in   producer word valid
//   wr_ready     out  FIFO not full
//   tx_data      out  word presented to the transmitter (registered)
//   send_en      out  one-cycle start pulse to the transmitter
//   tx_done      in   transmitter completion (rising edge is used)
//   fifo_level   out  words currently queued, 0..2**FIFO_AW
//   busy         out  FSM active or words queued
//   timeout_flag out  sticky, set when a word times out in WAIT
//   timeout_clr  in   clears timeout_flag (a same-cycle set wins)

module uart_tx_word_feeder #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_AW        = 3,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  send_en,
  input  logic                  tx_done,
  output logic [FIFO_AW:0]      fifo_level,
  output logic                  busy,
  output logic                  timeout_flag,
  input  logic                  timeout_clr
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [23:0] GAP_LAST     = (GAP_CYCLES > 0) ? 24'(GAP_CYCLES - 1) : 24'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_GAP
  } state_t;

  state_t state_reg, state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW:0]      wr_ptr_reg;
  logic [FIFO_AW:0]      rd_ptr_reg;
  logic [DATA_WIDTH-1:0] tx_data_reg;
  logic [23:0]           cnt_reg, cnt_next;
  logic                  tx_done_q_reg;
  logic                  timeout_flag_reg;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic done_edge;
  logic timeout_set;

  // Pointers carry one extra wrap bit: equal low bits with differing wrap
  // bits means the buffer is full, fully equal pointers mean empty.
  assign full  = (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]) &&
                 (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);

  assign wr_ready   = !full;
  assign push       = wr_valid && !full;
  assign fifo_level = wr_ptr_reg - rd_ptr_reg;
  assign done_edge  = tx_done && !tx_done_q_reg;

  assign tx_data      = tx_data_reg;
  assign timeout_flag = timeout_flag_reg;
  assign busy         = (state_reg != ST_IDLE) || !empty;

  // Storage has no reset so it can map onto RAM; emptiness is tracked by
  // the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[FIFO_AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // tx_data only changes on a pop, so it is stable for the whole transfer.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      tx_data_reg <= '0;
    end else if (pop) begin
      tx_data_reg <= mem[rd_ptr_reg[FIFO_AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      tx_done_q_reg    <= 1'b0;
      timeout_flag_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      tx_done_q_reg <= tx_done;
      if (timeout_set) begin
        timeout_flag_reg <= 1'b1;
      end else if (timeout_clr) begin
        timeout_flag_reg <= 1'b0;
      end
    end
  end

  // One counter serves both the WAIT timeout and the GAP delay; it is
  // cleared on entry to each of those states.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    pop         = 1'b0;
    send_en     = 1'b0;
    timeout_set = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        send_en    = 1'b1;
        cnt_next   = '0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion in the last allowed cycle still counts as success.
        if (done_edge) begin
          cnt_next   = '0;
          state_next = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          timeout_set = 1'b1;
          cnt_next    = '0;
          state_next  = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 24'd1;
        end
      end
      ST_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 24'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_word_feeder.sv
// Testbench for uart_tx_word_feeder. The transmitter is modelled inline:
// the bench raises tx_done a chosen number of cycles after send_en.
// All inputs change 1 time unit after a rising edge, outputs are read there.

module tb_uart_tx_word_feeder;

  localparam int GAP = 16;
  localparam int TO  = 100;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] tx_data;
  logic        send_en;
  logic        tx_done;
  logic [3:0]  fifo_level;
  logic        busy;
  logic        timeout_flag;
  logic        timeout_clr;

  uart_tx_word_feeder #(
    .DATA_WIDTH(32),
    .FIFO_AW(3),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .tx_data(tx_data),
    .send_en(send_en),
    .tx_done(tx_done),
    .fifo_level(fifo_level),
    .busy(busy),
    .timeout_flag(timeout_flag),
    .timeout_clr(timeout_clr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pulses   = 0;
  int dbl      = 0;
  logic prev_se = 1'b0;
  logic [31:0] rx_q[$];
  int          se_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter-side monitor: records every word handed over with send_en.
  always @(negedge clk) begin
    if (send_en) begin
      pulses <= pulses + 1;
      rx_q.push_back(tx_data);
      se_q.push_back(cyc);
      if (prev_se) dbl <= dbl + 1;
    end
    prev_se <= send_en;
  end

  typedef struct {
    logic [31:0] word;
    int          done_delay;
    int          exp_busy_steps;
  } vec_t;

  vec_t vecs[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_level"}, 64'(fifo_level), 64'(0));
    check({pfx, "_wr_ready"}, 64'(wr_ready), 64'(1));
    check({pfx, "_tx_data"}, 64'(tx_data), 64'(0));
    check({pfx, "_send_en"}, 64'(send_en), 64'(0));
    check({pfx, "_busy"}, 64'(busy), 64'(0));
    check({pfx, "_timeout_flag"}, 64'(timeout_flag), 64'(0));
  endtask

  task automatic push_word(input logic [31:0] w);
    int   b;
    logic acc;
    b = 0;
    acc = 1'b0;
    wr_data  = w;
    wr_valid = 1'b1;
    while (!acc && b < 400) begin
      acc = wr_ready;
      step();
      b++;
    end
    wr_valid = 1'b0;
    check("push_accept", 64'(acc), 64'(1));
    $display("push word=%h accepted_at=%0d level=%0d", w, cyc, fifo_level);
  endtask

  task automatic wait_send(output int c);
    int b;
    b = 0;
    while (!send_en && b < 400) begin
      step();
      b++;
    end
    check("send_seen", 64'(send_en), 64'(1));
    c = cyc;
    $display("send word=%h at=%0d", tx_data, c);
  endtask

  task automatic finish_word(input int n, output int m);
    repeat (n) step();
    tx_done = 1'b1;
    step();
    m = cyc;
    tx_done = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (busy && b < 400) begin
      step();
      b++;
    end
    check("idle_reached", 64'(busy), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int lvl_bad, p0, steps, c, m, se_a, se_b, flag_cyc, errs;
    logic [31:0] base;

    vecs[0] = '{32'h12345678, 1, 18};
    vecs[1] = '{32'hA5A5A5A5, 5, 22};
    vecs[2] = '{32'h00000001, 30, 47};
    vecs[3] = '{32'hFFFF0000, 100, 117};  // completes in the last WAIT cycle

    // Reset held with wr_valid high: nothing may be queued.
    nrst = 1'b0; wr_valid = 1'b1; wr_data = 32'hCAFEF00D;
    tx_done = 1'b0; timeout_clr = 1'b0;
    lvl_bad = 0;
    repeat (10) begin
      step();
      if (fifo_level != 0) lvl_bad++;
    end
    check("rst_level_hold", 64'(lvl_bad), 64'(0));
    check_reset("rst");
    wr_valid = 1'b0;
    nrst = 1'b1;
    step();

    // Table-driven single-word transfers.
    for (int i = 0; i < 4; i++) begin
      p0 = pulses;
      wr_data  = vecs[i].word;
      wr_valid = 1'b1;
      check("vec_ready", 64'(wr_ready), 64'(1));
      step();
      wr_valid = 1'b0;
      check("vec_level_push", 64'(fifo_level), 64'(1));
      check("vec_no_early_send", 64'(send_en), 64'(0));
      step();
      check("vec_send_en", 64'(send_en), 64'(1));
      check("vec_tx_data", 64'(tx_data), 64'(vecs[i].word));
      check("vec_level_pop", 64'(fifo_level), 64'(0));
      repeat (vecs[i].done_delay) step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      steps = vecs[i].done_delay + 1;
      while (busy && steps < 400) begin
        step();
        steps++;
      end
      check("vec_busy_cycles", 64'(steps), 64'(vecs[i].exp_busy_steps));
      check("vec_pulses", 64'(pulses - p0), 64'(1));
      check("vec_no_timeout", 64'(timeout_flag), 64'(0));
      check("vec_tx_data_hold", 64'(tx_data), 64'(vecs[i].word));
      $display("vec %0d word=%h done_delay=%0d busy_cycles=%0d", i, vecs[i].word,
               vecs[i].done_delay, steps);
    end

    // Burst of three: each next send_en lands GAP+1 cycles after completion.
    rx_q.delete(); se_q.delete(); p0 = pulses;
    push_word(32'h87654321);
    push_word(32'h24680135);
    push_word(32'hDEADBEEF);
    check("burst_level", 64'(fifo_level), 64'(2));
    finish_word(3, m);
    wait_send(c);
    check("burst_gap1", 64'(c - m), 64'(GAP + 1));
    finish_word(3, m);
    wait_send(c);
    check("burst_gap2", 64'(c - m), 64'(GAP + 1));
    finish_word(3, m);
    wait_idle();
    check("burst_pulses", 64'(pulses - p0), 64'(3));
    check("burst_rx_count", 64'(rx_q.size()), 64'(3));
    if (rx_q.size() == 3) begin
      check("burst_rx0", 64'(rx_q[0]), 64'(32'h87654321));
      check("burst_rx1", 64'(rx_q[1]), 64'(32'h24680135));
      check("burst_rx2", 64'(rx_q[2]), 64'(32'hDEADBEEF));
    end

    // Full FIFO: first word goes straight to the transmitter, eight fill.
    rx_q.delete(); p0 = pulses;
    base = 32'h1000_0000;
    for (int i = 0; i < 9; i++) push_word(base + 32'(i));
    check("full_level", 64'(fifo_level), 64'(8));
    check("full_wr_ready", 64'(wr_ready), 64'(0));
    wr_data = base + 32'd9;
    wr_valid = 1'b1;
    repeat (3) step();
    wr_valid = 1'b0;
    check("full_no_push", 64'(fifo_level), 64'(8));
    finish_word(2, m);
    wait_send(c);
    check("full_level_after_pop", 64'(fifo_level), 64'(7));
    check("full_ready_after_pop", 64'(wr_ready), 64'(1));
    push_word(base + 32'd9);
    check("full_refill_level", 64'(fifo_level), 64'(8));
    check("full_refill_ready", 64'(wr_ready), 64'(0));
    for (int i = 0; i < 9; i++) begin
      finish_word(2, m);
      if (i < 8) wait_send(c);
    end
    wait_idle();
    check("full_rx_count", 64'(rx_q.size()), 64'(10));
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < rx_q.size()) begin
        if (rx_q[i] != base + 32'(i)) errs++;
      end
    end
    check("full_rx_order", 64'(errs), 64'(0));

    // Timeout: never complete; flag after TO WAIT cycles, next word follows.
    rx_q.delete(); se_q.delete(); p0 = pulses;
    push_word(32'hAAAA0001);
    push_word(32'hBBBB0002);
    steps = 0;
    while (!timeout_flag && steps < 400) begin
      step();
      steps++;
    end
    flag_cyc = cyc;
    check("to_flag_set", 64'(timeout_flag), 64'(1));
    se_a = (se_q.size() > 0) ? se_q[0] : -1000;
    check("to_latency_a", 64'(flag_cyc - se_a), 64'(TO + 1));
    check("to_busy_next_queued", 64'(busy), 64'(1));
    step();
    check("to_next_send", 64'(send_en), 64'(1));
    check("to_next_data", 64'(tx_data), 64'(32'hBBBB0002));
    se_b = cyc;
    timeout_clr = 1'b1;
    step();
    check("to_clr", 64'(timeout_flag), 64'(0));
    steps = 0;
    while (!timeout_flag && steps < 400) begin
      step();
      steps++;
    end
    check("to_set_beats_clr", 64'(timeout_flag), 64'(1));
    check("to_latency_b", 64'(cyc - se_b), 64'(TO + 1));
    check("to_idle_after_drop", 64'(busy), 64'(0));
    step();
    check("to_clr_again", 64'(timeout_flag), 64'(0));
    timeout_clr = 1'b0;
    check("to_pulses", 64'(pulses - p0), 64'(2));
    $display("timeout test a_send=%0d b_send=%0d flag_at=%0d", se_a, se_b, flag_cyc);

    // Reset during WAIT with three words queued.
    push_word(32'h0000AAAA);
    push_word(32'h0000BBBB);
    push_word(32'h0000CCCC);
    push_word(32'h0000DDDD);
    check("mid_level_before", 64'(fifo_level), 64'(3));
    nrst = 1'b0;
    step();
    check_reset("mid");
    nrst = 1'b1;
    p0 = pulses;
    repeat (30) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    repeat (5) step();
    check("mid_no_send", 64'(pulses - p0), 64'(0));
    check("mid_busy", 64'(busy), 64'(0));
    check("mid_level_after", 64'(fifo_level), 64'(0));
    push_word(32'h5A5A5A5A);
    wait_send(c);
    check("mid_new_word", 64'(tx_data), 64'(32'h5A5A5A5A));
    finish_word(1, m);
    wait_idle();
    check("mid_no_timeout", 64'(timeout_flag), 64'(0));

    check("no_back_to_back_send_en", 64'(dbl), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
